// File: rtl/deserializador_fifo.sv
// deserializador_fifo
//   Assembles a serial bit stream into WORD_WIDTH-bit words (selectable bit
//   order) and queues completed words in a DEPTH-entry first-word-fall-through
//   buffer. The consumer sees the head word with a ready/ack handshake.
//
// Ports
//   clock_100khz   block clock, rising edge
//   reset          asynchronous active-low reset
//   data_in        serial bit, sampled when write_in is high
//   write_in       data_in valid this cycle
//   ack_in         consumer took data_out; pops the head word
//   clear_in       synchronous clear of partial word, buffer and overflow flag
//   status_out     block can accept a bit this cycle (buffer not full)
//   data_out       head word, 0 when buffer empty
//   data_ready     data_out holds a valid word
//   count_out      words buffered
//   bit_count_out  bits accumulated in the current partial word
//   overflow_out   sticky: a bit was offered while status_out was low
module deserializador_fifo #(
   parameter int WORD_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic                          clock_100khz,
   input  logic                          reset,
   input  logic                          data_in,
   input  logic                          write_in,
   input  logic                          ack_in,
   input  logic                          clear_in,
   output logic                          status_out,
   output logic [WORD_WIDTH-1:0]         data_out,
   output logic                          data_ready,
   output logic [$clog2(DEPTH+1)-1:0]    count_out,
   output logic [$clog2(WORD_WIDTH)-1:0] bit_count_out,
   output logic                          overflow_out
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int BW = $clog2(WORD_WIDTH);
   // DEPTH=1 would give a zero-width pointer; keep at least one bit.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   logic                  accept, push, pop, last_bit;
   logic [WORD_WIDTH-1:0] shifted;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign status_out    = (count_q < CW'(DEPTH));
   assign data_ready    = (count_q != '0);
   assign data_out      = data_ready ? mem_q[rd_ptr_q] : '0;
   assign count_out     = count_q;
   assign bit_count_out = bit_cnt_q;
   assign overflow_out  = ovf_q;

   always_comb begin
      accept   = write_in & status_out;
      pop      = ack_in & data_ready;
      last_bit = (bit_cnt_q == BW'(WORD_WIDTH-1));
      push     = accept & last_bit;
      shifted  = (MSB_FIRST != 0) ? {shift_q[WORD_WIDTH-2:0], data_in}
                                  : {data_in, shift_q[WORD_WIDTH-1:1]};

      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;

      if (clear_in) begin
         shift_d   = '0;
         bit_cnt_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         ovf_d     = 1'b0;
      end else begin
         if (accept) begin
            shift_d   = shifted;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
         end
         if (write_in && !status_out) ovf_d = 1'b1;
         if (push) wr_ptr_d = ptr_next(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock_100khz or negedge reset) begin
      if (!reset) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: data_out is forced to 0 while the buffer is empty.
   // The completed word includes the bit accepted on this edge (shifted).
   always_ff @(posedge clock_100khz) begin
      if (push && !clear_in) mem_q[wr_ptr_q] <= shifted;
   end

endmodule

// File: tb/tb_deserializador_fifo.sv
module tb_deserializador_fifo;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instances A (8/4/MSB first) and C (8/4/LSB first) share stimulus.
   logic din, wr, ack, clr;
   logic       sa_st, sa_rdy, sa_ovf;
   logic [7:0] sa_data;
   logic [2:0] sa_cnt, sa_bc;
   logic       sc_st, sc_rdy, sc_ovf;
   logic [7:0] sc_data;
   logic [2:0] sc_cnt, sc_bc;
   // Instance B: 12-bit words, 3-deep buffer.
   logic dinb, wrb, ackb, clrb;
   logic        sb_st, sb_rdy, sb_ovf;
   logic [11:0] sb_data;
   logic [1:0]  sb_cnt;
   logic [3:0]  sb_bc;

   deserializador_fifo #(.WORD_WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_a (
      .clock_100khz(clk), .reset(rst_n), .data_in(din), .write_in(wr),
      .ack_in(ack), .clear_in(clr), .status_out(sa_st), .data_out(sa_data),
      .data_ready(sa_rdy), .count_out(sa_cnt), .bit_count_out(sa_bc),
      .overflow_out(sa_ovf));

   deserializador_fifo #(.WORD_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_c (
      .clock_100khz(clk), .reset(rst_n), .data_in(din), .write_in(wr),
      .ack_in(ack), .clear_in(clr), .status_out(sc_st), .data_out(sc_data),
      .data_ready(sc_rdy), .count_out(sc_cnt), .bit_count_out(sc_bc),
      .overflow_out(sc_ovf));

   deserializador_fifo #(.WORD_WIDTH(12), .DEPTH(3), .MSB_FIRST(1)) u_b (
      .clock_100khz(clk), .reset(rst_n), .data_in(dinb), .write_in(wrb),
      .ack_in(ackb), .clear_in(clrb), .status_out(sb_st), .data_out(sb_data),
      .data_ready(sb_rdy), .count_out(sb_cnt), .bit_count_out(sb_bc),
      .overflow_out(sb_ovf));

   int errors = 0;
   int checks = 0;
   logic [7:0]  qa[$];
   logic [7:0]  qc[$];
   logic [11:0] qb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   // Compare the head word against the scoreboard when it is about to be popped.
   task automatic auto_pop_ac();
      if (ack && sa_rdy) begin
         if (qa.size() == 0) chk("a_unexpected_word", sa_rdy, 1'b0);
         else chk("a_pop_data", sa_data, qa.pop_front());
      end
      if (ack && sc_rdy) begin
         if (qc.size() == 0) chk("c_unexpected_word", sc_rdy, 1'b0);
         else chk("c_pop_data", sc_data, qc.pop_front());
      end
   endtask

   task automatic bit_ac(input logic b);
      din = b; wr = 1'b1;
      step();
      wr = 1'b0;
      if (ack) begin
         chk("stream_count_le1", sa_cnt <= 3'd1, 1'b1);
         chk("stream_ovf", sa_ovf, 1'b0);
      end
      auto_pop_ac();
   endtask

   task automatic word_ac(input logic [7:0] w);
      qa.push_back(w);
      qc.push_back(rev8(w));
      for (int i = 7; i >= 0; i--) bit_ac(w[i]);
   endtask

   task automatic pop_ac();
      chk("a_ready", sa_rdy, 1'b1);
      chk("c_ready", sc_rdy, 1'b1);
      ack = 1'b1;
      auto_pop_ac();
      step();
      ack = 1'b0;
   endtask

   task automatic word_b(input logic [11:0] w);
      qb.push_back(w);
      for (int i = 11; i >= 0; i--) begin
         dinb = w[i]; wrb = 1'b1;
         step();
         wrb = 1'b0;
      end
   endtask

   task automatic pop_b();
      chk("b_ready", sb_rdy, 1'b1);
      if (qb.size() == 0) chk("b_unexpected_word", sb_rdy, 1'b0);
      else chk("b_pop_data", sb_data, qb.pop_front());
      ackb = 1'b1;
      step();
      ackb = 1'b0;
   endtask

   initial begin
      logic [7:0]  w;
      logic [11:0] wb;
      rst_n = 1'b0;
      din = 0; wr = 0; ack = 0; clr = 0;
      dinb = 0; wrb = 0; ackb = 0; clrb = 0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_status", sa_st, 1'b1);
      chk("rst_ready", sa_rdy, 1'b0);
      chk("rst_count", sa_cnt, 3'd0);
      chk("b_rst_status", sb_st, 1'b1);
      chk("b_rst_data", sb_data, 12'h000);

      // Reset in the middle of a word discards the partial bits.
      bit_ac(1'b1); bit_ac(1'b1); bit_ac(1'b1);
      chk("mid_bitcount", sa_bc, 3'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("inrst_status", sa_st, 1'b1);
      chk("inrst_data", sa_data, 8'h00);
      chk("inrst_ready", sa_rdy, 1'b0);
      chk("inrst_count", sa_cnt, 3'd0);
      chk("inrst_bitcount", sa_bc, 3'd0);
      chk("inrst_ovf", sa_ovf, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("postrst_bitcount", sa_bc, 3'd0);
      word_ac(8'h5A);
      chk("fresh_count", sa_cnt, 3'd1);
      pop_ac();

      // Bit order and one-cycle latency.
      w = 8'hA5;
      qa.push_back(w); qc.push_back(rev8(w));
      for (int i = 7; i >= 1; i--) bit_ac(w[i]);
      chk("a5_not_ready", sa_rdy, 1'b0);
      chk("a5_bitcount7", sa_bc, 3'd7);
      bit_ac(w[0]);
      chk("a5_ready", sa_rdy, 1'b1);
      chk("a5_data", sa_data, 8'hA5);
      chk("a5_count", sa_cnt, 3'd1);
      chk("a5_bitcount0", sa_bc, 3'd0);
      pop_ac();
      word_ac(8'hC0);
      chk("lsb_first_03", sc_data, 8'h03);
      pop_ac();
      chk("empty_data", sa_data, 8'h00);

      // Fill, then overflow.
      word_ac(8'h11); word_ac(8'h22); word_ac(8'h33); word_ac(8'h44);
      chk("full_count", sa_cnt, 3'd4);
      chk("full_status", sa_st, 1'b0);
      chk("noovf_yet", sa_ovf, 1'b0);
      din = 1'b1; wr = 1'b1;
      step();
      wr = 1'b0;
      chk("ovf_set", sa_ovf, 1'b1);
      chk("ovf_bitcount", sa_bc, 3'd0);
      chk("ovf_count", sa_cnt, 3'd4);
      pop_ac();
      chk("status_after_pop", sa_st, 1'b1);
      pop_ac(); pop_ac(); pop_ac();
      chk("drained_ready", sa_rdy, 1'b0);
      chk("drained_data", sa_data, 8'h00);
      chk("ovf_sticky", sa_ovf, 1'b1);

      // clear_in wins over write_in and ack_in.
      word_ac(8'h96); word_ac(8'h69);
      bit_ac(1'b1); bit_ac(1'b0); bit_ac(1'b1); bit_ac(1'b1); bit_ac(1'b0);
      chk("preclr_count", sa_cnt, 3'd2);
      chk("preclr_bitcount", sa_bc, 3'd5);
      clr = 1'b1; wr = 1'b1; ack = 1'b1; din = 1'b1;
      step();
      clr = 1'b0; wr = 1'b0; ack = 1'b0;
      qa.delete(); qc.delete();
      chk("clr_count", sa_cnt, 3'd0);
      chk("clr_bitcount", sa_bc, 3'd0);
      chk("clr_ready", sa_rdy, 1'b0);
      chk("clr_ovf", sa_ovf, 1'b0);
      chk("clr_status", sa_st, 1'b1);
      word_ac(8'h3C);
      pop_ac();

      // Continuous ack while streaming: every word once, in order.
      ack = 1'b1;
      for (int n = 0; n < 10; n++) word_ac(8'($urandom_range(0, 255)));
      step();
      auto_pop_ac();
      step();
      auto_pop_ac();
      ack = 1'b0;
      chk("stream_all_popped", qa.size(), 32'd0);
      chk("stream_end_count", sa_cnt, 3'd0);
      chk("stream_end_ovf", sa_ovf, 1'b0);

      // 12-bit words, 3-deep buffer.
      wb = 12'hABC;
      qb.push_back(wb);
      for (int i = 11; i >= 1; i--) begin
         dinb = wb[i]; wrb = 1'b1; step(); wrb = 1'b0;
      end
      chk("b_11bits_count", sb_cnt, 2'd0);
      chk("b_11bits_bc", sb_bc, 4'd11);
      dinb = wb[0]; wrb = 1'b1; step(); wrb = 1'b0;
      chk("b_12bits_count", sb_cnt, 2'd1);
      chk("b_12bits_bc", sb_bc, 4'd0);
      pop_b();
      for (int r = 0; r < 3; r++) begin
         word_b(12'($urandom_range(0, 4095)));
         word_b(12'($urandom_range(0, 4095)));
         chk("b_status_2", sb_st, 1'b1);
         word_b(12'($urandom_range(0, 4095)));
         chk("b_status_full", sb_st, 1'b0);
         chk("b_count_full", sb_cnt, 2'd3);
         pop_b(); pop_b(); pop_b();
         chk("b_empty", sb_rdy, 1'b0);
      end
      chk("b_ovf", sb_ovf, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/deserializador_fifo.md
Name: deserializador_fifo

Overview:
- Parametrised successor to the team's 8-bit serial-to-parallel deserializer.
- Assembles a serial bit stream into WORD_WIDTH-bit words with a selectable bit order.
- Queues completed words in a DEPTH-entry first-word-fall-through buffer.
- Presents the head word to the consumer (the stack) with a ready/ack handshake, so the serial producer can keep streaming while the consumer is slow.

Parameters:
- WORD_WIDTH, 8: bits per assembled word (≥2).
- DEPTH, 4: number of completed words buffered (≥1; need not be a power of 2).
- MSB_FIRST, 1: 1 = first accepted bit lands in bit WORD_WIDTH-1; 0 = first accepted bit lands in bit 0.

Ports:
- clock_100khz  input  1  single block clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data bit, sampled when write_in is high.
- write_in  input  1  data_in is valid this cycle.
- ack_in  input  1  consumer has taken data_out; pops the head word.
- clear_in  input  1  synchronous clear of partial word, buffer and overflow flag.
- status_out  output  1  high = block can accept a bit this cycle.
- data_out  output  WORD_WIDTH  head word of the buffer.
- data_ready  output  1  data_out holds a valid word.
- count_out  output  $clog2(DEPTH+1)  number of words buffered.
- bit_count_out  output  $clog2(WORD_WIDTH)  bits accumulated in the current partial word.
- overflow_out  output  1  sticky: a bit was offered while status_out was low.

Behaviour:
- Reset (reset low, asynchronous)
  - Clears shift register, bit counter, buffer pointers and count.
  - Output values while and after reset: status_out=1, data_out=0, data_ready=0, count_out=0, bit_count_out=0, overflow_out=0.
  - A reset mid-word discards the partial word.
- clear_in (sampled high on a clock edge)
  - Same effect as reset; takes priority over write_in and ack_in in that cycle.
- status_out
  - Combinational: status_out = (count_out < DEPTH).
- Bit acceptance
  - A bit is accepted on an edge where write_in=1 and status_out=1.
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WORD_WIDTH-1.
  - bit_count_out increments on each accepted bit.
- Word completion
  - On the edge accepting the WORD_WIDTH-th bit, the completed word (including that bit) is written to the buffer tail.
  - On that same edge bit_count_out wraps to 0 and count_out increments.
  - data_ready/data_out reflect the new word on the following cycle, i.e. one-cycle latency from the last bit edge when the buffer was empty.
- Rejected bit
  - write_in=1 while status_out=0: the bit is ignored, the shift register and counter are unchanged, and overflow_out is set.
  - overflow_out stays set until reset or clear_in.
- Read side (first-word-fall-through)
  - data_out = buffer head when count_out>0, otherwise 0.
  - data_ready = (count_out>0).
  - ack_in=1 with data_ready=1 pops the head on that edge.
  - ack_in with data_ready=0 is ignored with no error.
- Simultaneous push and pop on one edge
  - count_out is unchanged; both pointers advance.
  - With the buffer full, no push is possible (status_out=0); a pop makes status_out high from the next cycle.
  - status_out never depends combinationally on ack_in.
- Pointer wrap
  - Read and write pointers wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
- Clock-domain rule
  - All inputs are synchronous to clock_100khz. Synchronisation of inputs from the stack's clock domain is done outside this block.

Test Plan:
- Reset value check: assert reset low mid-word (after 3 bits), release → all outputs at reset values; the next 8 bits form a fresh word.
- Bit order, WORD_WIDTH=8, MSB_FIRST=1, DEPTH=4: feed bits 1,0,1,0,0,1,0,1 on consecutive cycles → one cycle after the 8th bit, data_ready=1, data_out=8'hA5, count_out=1.
  - MSB_FIRST=0, same stream → data_out=8'hA5 reversed = 8'hA5 (palindrome), so also run 1,1,0,0,0,0,0,0 → data_out=8'h03.
- Fill and overflow: stream 4 words 8'h11, 8'h22, 8'h33, 8'h44 with ack_in=0 → count_out=4, status_out=0.
  - A further write_in pulse → overflow_out=1; the pulse is not counted (bit_count_out=0).
  - Ack 4 times → data_out reads 11, 22, 33, 44 in order, then data_ready=0 and data_out=0.
- Concurrent push/pop: hold ack_in=1 continuously while streaming 10 words → every word appears once, in order; count_out ≤1; overflow_out stays 0; pointers wrap correctly.
- clear_in: with 2 words buffered and 5 bits pending, pulse clear_in together with write_in and ack_in → next cycle count_out=0, bit_count_out=0, data_ready=0, overflow_out=0.
- Parameter sweep: WORD_WIDTH=12, DEPTH=3 → a word completes after exactly 12 accepted bits; status_out drops after the 3rd word; wrap-around is correct over 9 words.
